// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: rebuilds hc/vc from active-low hsync/vsync,
// measures line length and frame height, and locks onto the expected timing.
module vga_sync_decoder #(
    parameter int unsigned HPIXELS     = 800,
    parameter int unsigned VLINES      = 521,
    parameter int unsigned HBP         = 144,
    parameter int unsigned HFP         = 784,
    parameter int unsigned VBP         = 31,
    parameter int unsigned VFP         = 511,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  hc,
    output logic [9:0]  vc,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic        de,
    output logic        frame_start
);

    localparam logic [1:0]  ST_SEARCH = 2'd0;
    localparam logic [1:0]  ST_VERIFY = 2'd1;
    localparam logic [1:0]  ST_LOCKED = 2'd2;

    localparam logic [9:0]  CNT_MAX  = 10'd1023;
    localparam logic [10:0] HPIX_C   = 11'(HPIXELS);
    localparam logic [10:0] VLIN_C   = 11'(VLINES);
    localparam logic [9:0]  HBP_C    = 10'(HBP);
    localparam logic [9:0]  HFP_C    = 10'(HFP);
    localparam logic [9:0]  VBP_C    = 10'(VBP);
    localparam logic [9:0]  VFP_C    = 10'(VFP);
    localparam logic [2:0]  LOCK_C   = 3'(LOCK_FRAMES);

    logic        r_hs_r, r_hs_rr, r_vs_r, r_vs_rr;
    logic [9:0]  r_hc, r_vc;
    logic [10:0] r_line_len, r_frame_lines;
    logic        r_locked, r_frame_start;
    logic [1:0]  r_state;
    logic [2:0]  r_good_cnt;
    logic        r_frame_bad;

    logic        w_fall_h, w_fall_v;
    logic [10:0] w_hc_inc, w_vc_inc;
    logic        w_line_bad, w_frame_mis, w_saturated;
    logic [2:0]  w_good_next;

    // NOTE: sync stages reset to the idle-high level so reset itself never
    // looks like a falling sync edge.
    always_ff @(posedge dclk) begin
        if (rst) begin
            r_hs_r  <= 1'b1;
            r_hs_rr <= 1'b1;
            r_vs_r  <= 1'b1;
            r_vs_rr <= 1'b1;
        end else begin
            r_hs_r  <= hsync_in;
            r_hs_rr <= r_hs_r;
            r_vs_r  <= vsync_in;
            r_vs_rr <= r_vs_r;
        end
    end

    assign w_fall_h    = r_hs_rr & ~r_hs_r;
    assign w_fall_v    = r_vs_rr & ~r_vs_r;
    assign w_hc_inc    = {1'b0, r_hc} + 11'd1;
    assign w_vc_inc    = {1'b0, r_vc} + 11'd1;
    assign w_line_bad  = w_fall_h & (w_hc_inc != HPIX_C);
    assign w_frame_mis = w_fall_v & (w_vc_inc != VLIN_C);
    assign w_saturated = (r_hc == CNT_MAX) | (r_vc == CNT_MAX);
    assign w_good_next = r_good_cnt + 3'd1;

    // A vsync edge resets vc even when an hsync edge lands on the same cycle.
    always_ff @(posedge dclk) begin
        if (rst) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_fall_h) begin
                r_hc       <= '0;
                r_line_len <= w_hc_inc;
            end else if (r_hc != CNT_MAX) begin
                r_hc <= r_hc + 10'd1;
            end

            if (w_fall_v) begin
                r_vc          <= '0;
                r_frame_lines <= w_vc_inc;
            end else if (w_fall_h && (r_vc != CNT_MAX)) begin
                r_vc <= r_vc + 10'd1;
            end

            r_frame_start <= w_fall_v;
        end
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_good_cnt  <= '0;
            r_frame_bad <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_fall_v) begin
                        r_state     <= ST_VERIFY;
                        r_good_cnt  <= '0;
                        r_frame_bad <= 1'b0;
                    end
                end
                ST_VERIFY: begin
                    if (w_fall_v) begin
                        r_frame_bad <= 1'b0;
                        if (r_frame_bad || w_frame_mis || w_line_bad) begin
                            r_good_cnt <= '0;
                        end else if (w_good_next == LOCK_C) begin
                            r_good_cnt <= w_good_next;
                            r_state    <= ST_LOCKED;
                            r_locked   <= 1'b1;
                        end else begin
                            r_good_cnt <= w_good_next;
                        end
                    end else if (w_line_bad) begin
                        r_frame_bad <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Counters keep running after loss of lock; only the state drops.
                    if (w_line_bad || w_frame_mis || w_saturated) begin
                        r_state    <= ST_SEARCH;
                        r_locked   <= 1'b0;
                        r_good_cnt <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign hc          = r_hc;
    assign vc          = r_vc;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign de          = r_locked & (r_hc >= HBP_C) & (r_hc < HFP_C)
                                  & (r_vc >= VBP_C) & (r_vc < VFP_C);

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Sink-side counterpart of the 640x480 timing generator. Takes active-low hsync/vsync on the 25 MHz pixel clock and rebuilds the horizontal/vertical position counters.
- Measures line length and frame height, and declares lock when the timing matches the expected 800x521 format.
- Drives a data-enable and a frame-start strobe for downstream capture, checker and overlay logic. It sits on the receive side of any link or loopback that carries VGA sync.

Parameters:
HPIXELS, 800, expected dclk cycles per line
VLINES, 521, expected lines per frame
HBP, 144, first active hc
HFP, 784, first inactive hc after active region
VBP, 31, first active vc
VFP, 511, first inactive vc after active region
LOCK_FRAMES, 2, consecutive clean full frames required to lock (1..7)

Ports:
dclk  input  1  pixel clock, 25 MHz; all logic on rising edge
rst  input  1  synchronous, active-high reset
hsync_in  input  1  horizontal sync, active low
vsync_in  input  1  vertical sync, active low
hc  output  10  recovered horizontal counter
vc  output  10  recovered vertical counter
line_len  output  11  cycle count of last completed line
frame_lines  output  11  line count of last completed frame
locked  output  1  timing matches parameters
de  output  1  active-video enable
frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset (rst=1 at an edge): hc=0, vc=0, line_len=0, frame_lines=0, locked=0, frame_start=0, state=SEARCH, good_cnt=0, frame_bad=0.
  - Sync pipeline registers hs_r, hs_rr, vs_r, vs_rr reset to 1 (idle), so no false edge is seen after reset.
- Input stage: hs_r<=hsync_in, hs_rr<=hs_r; same for vsync.
  - fall_h = hs_rr & ~hs_r.
  - fall_v = vs_rr & ~vs_r.
- Horizontal counting:
  - On fall_h: hc<=0 and line_len<=hc+1 (11-bit).
  - Otherwise hc<=hc+1, saturating at 1023.
  - Net effect: hc lags the source counter by exactly 2 cycles. With a conforming 800-cycle source, hc runs 0..799 and line_len=800.
- Vertical counting:
  - On fall_v: vc<=0 and frame_lines<=vc+1. This applies with or without a coincident fall_h.
  - Else on fall_h: vc<=vc+1, saturating at 1023.
  - Conforming source: vc runs 0..520 and frame_lines=521.
- frame_start: registered, =1 for exactly the one cycle following a fall_v edge. That cycle is the one where hc=0 and vc=0 for an aligned source.
- de: combinational from registered state. de = locked & (HBP<=hc<HFP) & (VBP<=vc<VFP).
- Lock state machine (locked is registered and updates one cycle after the deciding edge):
  - line_bad = fall_h & (hc+1 != HPIXELS).
  - frame_mis = fall_v & (vc+1 != VLINES).
  - SEARCH: on fall_v go to VERIFY with good_cnt=0 and frame_bad=0. Nothing else is evaluated.
  - VERIFY:
    - line_bad sets frame_bad.
    - On fall_v: if frame_bad, frame_mis, or line_bad in the same cycle, then good_cnt=0 and frame_bad=0.
    - Otherwise good_cnt+1; when good_cnt reaches LOCK_FRAMES, go to LOCKED and locked<=1.
    - frame_bad clears on every fall_v.
  - LOCKED:
    - Any line_bad, frame_mis, hc==1023 or vc==1023 goes to SEARCH with locked<=0 next cycle and good_cnt=0.
    - Counters keep running; there is no freeze.
- Simultaneous fall_h and fall_v (the normal case): vertical reset wins over vc increment. Line check and frame check are both evaluated on that edge.
- Missing sync: hc/vc saturate and never wrap. Saturation forces loss of lock. line_len reports 1024 at the next fall_h if the gap was at least 1024 cycles.
- vsync with no coincident hsync: accepted as frame boundary (vc<=0); lock is judged only by counts.
- Reset mid-frame: state returns to SEARCH and lock needs a fresh fall_v plus LOCK_FRAMES clean frames.

Test Plan:
- Conforming source (800x521, hsync low 96, vsync low 2), rst released at arbitrary phase -> locked rises 1 cycle after the 3rd fall_v; then line_len=800, frame_lines=521, hc tracks source hc-2 (mod 800).
- Locked, active region -> de=1 exactly for hc 144..783 with vc 31..510; 640x480=307200 de cycles per frame; frame_start one pulse per 416800 cycles.
- Locked, one line stretched to 801 cycles -> line_len=801, locked=0 next cycle, relock only after a following fall_v plus 2 clean frames.
- Source with 525 lines -> frame_lines=525 each frame, locked never asserts.
- Hsync held high 2000 cycles while locked -> hc stops at 1023, locked=0; on resumed hsync, line_len=1024.
- rst asserted 1 cycle mid-frame while locked -> next cycle all outputs 0, hc/vc=0; no frame_start until the next real vsync fall.
